// File: rtl/elevator_request_panel.sv
// rtl/elevator_request_panel.sv - debounced elevator request latches served by a door-watch FSM
//
// Purpose: synchronizes and debounces six raw request buttons, latches each
// accepted press as a pending request, and clears the requests for the
// current floor whenever the door reaches fully open. Tracks how long each
// request has waited and raises a sticky flag if any waits too long.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   btn_fb[2:0]       raw in-car buttons, bit n-1 = floor n (async, bouncy)
//   btn_call[2:0]     raw hall-call buttons, bit n-1 = floor n (async, bouncy)
//   FI[7:1]           floor-indicator segment code, bits 7..1 = segments a..g
//   DOOR[5:0]         door pattern from the controller
//   FB1..FB3          pending in-car requests
//   CALL1..CALL3      pending hall calls
//   lamp[5:0]         {call[3:1], fb[3:1]} button lamps
//   pending_cnt[2:0]  number of pending requests
//   stuck             sticky: some request waited STUCK_CYCLES cycles

module elevator_request_panel #(
  parameter int DEB_CYCLES   = 4,
  parameter int STUCK_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] btn_fb,
  input  logic [2:0] btn_call,
  input  logic [7:1] FI,
  input  logic [5:0] DOOR,
  output logic       FB1,
  output logic       FB2,
  output logic       FB3,
  output logic       CALL1,
  output logic       CALL2,
  output logic       CALL3,
  output logic [5:0] lamp,
  output logic [2:0] pending_cnt,
  output logic       stuck
);

  // Debounce counter only needs to reach DEB_CYCLES-1.
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [11:0]   STUCK_W  = 12'(STUCK_CYCLES);

  typedef enum logic [1:0] {
    ST_CLOSED,
    ST_OPENING,
    ST_OPEN,
    ST_CLOSING
  } door_st_t;

  // Button vectors are packed {call[2:0], fb[2:0]} throughout.
  logic [5:0]    w_raw;
  logic [5:0]    r_sync1;
  logic [5:0]    r_sync2;
  logic [5:0]    r_acc;
  logic [5:0]    r_rise;
  logic [CW-1:0] r_deb_cnt [6];

  door_st_t      r_state;
  logic          w_door_closed;
  logic          w_door_open;
  logic          w_enter_open;
  logic [1:0]    w_floor;
  logic [5:0]    w_clr;

  logic [5:0]    r_pend;
  logic [5:0]    w_pend_next;
  logic [2:0]    r_cnt;
  logic [2:0]    w_cnt_next;
  logic [10:0]   r_age [6];
  logic          w_age_hit;
  logic          r_stuck;

  assign w_raw = {btn_call, btn_fb};

  // Synchronizer and per-button debounce. A sample equal to the accepted
  // level restarts the run; DEB_CYCLES differing samples in a row flip it.
  // r_rise marks an accepted 0->1 so the latch sets on the following edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_acc   <= '0;
      r_rise  <= '0;
      for (int i = 0; i < 6; i++) begin
        r_deb_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 6; i++) begin
        r_rise[i] <= 1'b0;
        if (r_sync2[i] == r_acc[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_acc[i]     <= r_sync2[i];
          r_rise[i]    <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Floor-indicator decode; 0 means unknown and never serves anything.
  always_comb begin
    w_floor = 2'd0;
    case (FI)
      7'b0110000: w_floor = 2'd1;
      7'b1101101: w_floor = 2'd2;
      7'b1111001: w_floor = 2'd3;
      default:    w_floor = 2'd0;
    endcase
  end

  assign w_door_closed = (DOOR == 6'b111111);
  assign w_door_open   = (DOOR == 6'b000000);
  // Every non-OPEN state moves to OPEN on a fully-open pattern.
  assign w_enter_open  = (r_state != ST_OPEN) && w_door_open;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CLOSED;
    end else begin
      case (r_state)
        ST_CLOSED: begin
          if (w_door_open) begin
            r_state <= ST_OPEN;
          end else if (!w_door_closed) begin
            r_state <= ST_OPENING;
          end
        end
        ST_OPENING: begin
          if (w_door_open) begin
            r_state <= ST_OPEN;
          end
        end
        ST_OPEN: begin
          if (!w_door_open) begin
            r_state <= ST_CLOSING;
          end
        end
        ST_CLOSING: begin
          if (w_door_closed) begin
            r_state <= ST_CLOSED;
          end else if (w_door_open) begin
            r_state <= ST_OPEN;
          end
        end
        default: r_state <= ST_CLOSED;
      endcase
    end
  end

  // Service mask: both the in-car and hall latch of the served floor.
  always_comb begin
    w_clr = 6'b000000;
    if (w_enter_open) begin
      case (w_floor)
        2'd1:    w_clr = 6'b001001;
        2'd2:    w_clr = 6'b010010;
        2'd3:    w_clr = 6'b100100;
        default: w_clr = 6'b000000;
      endcase
    end
  end

  // Clear beats a same-edge set on the served floor.
  assign w_pend_next = (r_pend | r_rise) & ~w_clr;

  always_comb begin
    w_cnt_next = 3'd0;
    for (int i = 0; i < 6; i++) begin
      w_cnt_next = w_cnt_next + {2'b00, w_pend_next[i]};
    end
  end

  always_comb begin
    w_age_hit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if ({1'b0, r_age[i]} >= STUCK_W) begin
        w_age_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend  <= '0;
      r_cnt   <= '0;
      r_stuck <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        r_age[i] <= '0;
      end
    end else begin
      r_pend <= w_pend_next;
      r_cnt  <= w_cnt_next;
      for (int i = 0; i < 6; i++) begin
        if (r_pend[i] && w_pend_next[i]) begin
          if (r_age[i] != 11'h7FF) begin
            r_age[i] <= r_age[i] + 11'd1;
          end
        end else begin
          r_age[i] <= '0;
        end
      end
      if (w_age_hit) begin
        r_stuck <= 1'b1;
      end
    end
  end

  assign FB1         = r_pend[0];
  assign FB2         = r_pend[1];
  assign FB3         = r_pend[2];
  assign CALL1       = r_pend[3];
  assign CALL2       = r_pend[4];
  assign CALL3       = r_pend[5];
  assign lamp        = r_pend;
  assign pending_cnt = r_cnt;
  assign stuck       = r_stuck;

endmodule

// File: tb/tb_elevator_request_panel.sv
// tb/tb_elevator_request_panel.sv - bench for elevator_request_panel
module tb_elevator_request_panel;

  localparam int DEB = 4;
  localparam int STK = 1024;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn_fb;
  logic [2:0] btn_call;
  logic [6:0] FI;
  logic [5:0] DOOR;
  logic       FB1, FB2, FB3, CALL1, CALL2, CALL3;
  logic [5:0] lamp;
  logic [2:0] pending_cnt;
  logic       stuck;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  elevator_request_panel #(
    .DEB_CYCLES  (DEB),
    .STUCK_CYCLES(STK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_fb     (btn_fb),
    .btn_call   (btn_call),
    .FI         (FI),
    .DOOR       (DOOR),
    .FB1        (FB1),
    .FB2        (FB2),
    .FB3        (FB3),
    .CALL1      (CALL1),
    .CALL2      (CALL2),
    .CALL3      (CALL3),
    .lamp       (lamp),
    .pending_cnt(pending_cnt),
    .stuck      (stuck)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: door states by name, raw button history per edge,
  // and the edge number at which each request became pending.
  typedef enum {M_CLOSED, M_OPENING, M_OPEN, M_CLOSING} mdoor_t;
  mdoor_t     m_door;
  logic [5:0] m_hist[$];
  logic [5:0] m_acc;
  logic [5:0] m_rise;
  logic [5:0] m_pend;
  bit         m_stuck;
  int         m_set_at[6];
  int         edge_no = 0;
  bit         chk_en  = 0;

  function automatic int floor_of(input logic [6:0] code);
    case (code)
      7'b0110000: return 1;
      7'b1101101: return 2;
      7'b1111001: return 3;
      default:    return 0;
    endcase
  endfunction

  // Raw button value sampled k+1 edges ago; zero before history begins.
  function automatic logic [5:0] past(input int k);
    if (k < m_hist.size()) return m_hist[k];
    return 6'd0;
  endfunction

  always @(posedge clk) begin : model
    logic [5:0] newacc, clr, nxt, smp;
    int         fl;
    bit         enter, all_diff;
    edge_no++;
    if (reset) begin
      m_hist.delete();
      m_acc   = '0;
      m_rise  = '0;
      m_pend  = '0;
      m_stuck = 1'b0;
      m_door  = M_CLOSED;
    end else begin
      // A request waiting STK cycles before this edge trips the flag.
      for (int i = 0; i < 6; i++) begin
        if (m_pend[i] && (edge_no - 1 - m_set_at[i]) >= STK) m_stuck = 1'b1;
      end
      enter = (m_door != M_OPEN) && (DOOR == 6'b000000);
      fl    = floor_of(FI);
      clr   = '0;
      if (enter && fl != 0) begin
        clr[fl - 1] = 1'b1;
        clr[fl + 2] = 1'b1;
      end
      nxt = (m_pend | m_rise) & ~clr;
      for (int i = 0; i < 6; i++) begin
        if (nxt[i] && !m_pend[i]) m_set_at[i] = edge_no;
      end
      m_pend = nxt;

      case (m_door)
        M_CLOSED:  if (DOOR == 6'b000000) m_door = M_OPEN;
                   else if (DOOR != 6'b111111) m_door = M_OPENING;
        M_OPENING: if (DOOR == 6'b000000) m_door = M_OPEN;
        M_OPEN:    if (DOOR != 6'b000000) m_door = M_CLOSING;
        M_CLOSING: if (DOOR == 6'b111111) m_door = M_CLOSED;
                   else if (DOOR == 6'b000000) m_door = M_OPEN;
        default:   m_door = M_CLOSED;
      endcase

      // A level is accepted once the last DEB synchronized samples (two
      // edges of synchronizer delay) all disagree with the accepted level.
      newacc = m_acc;
      for (int b = 0; b < 6; b++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= DEB; j++) begin
          smp = past(j);
          if (smp[b] == m_acc[b]) all_diff = 1'b0;
        end
        if (all_diff) newacc[b] = ~m_acc[b];
      end
      m_rise = newacc & ~m_acc;
      m_acc  = newacc;
      m_hist.push_front({btn_call, btn_fb});
      if (m_hist.size() > DEB + 2) void'(m_hist.pop_back());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pend", {26'd0, CALL3, CALL2, CALL1, FB3, FB2, FB1}, {26'd0, m_pend});
      check("lamp", {26'd0, lamp}, {26'd0, m_pend});
      check("cnt", {29'd0, pending_cnt}, $countones(m_pend));
      check("stuck", {31'd0, stuck}, {31'd0, m_stuck});
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic random_phase(input int n);
    logic [5:0] btn;
    int         hold;
    btn  = '0;
    hold = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int b = 0; b < 6; b++) begin
        if ($urandom_range(0, 29) == 0) btn[b] = ~btn[b];
      end
      {btn_call, btn_fb} = btn;
      if (hold == 0) begin
        case ($urandom_range(0, 5))
          0:       DOOR = 6'b111111;
          1:       DOOR = 6'b110011;
          2:       DOOR = 6'b100001;
          3:       DOOR = 6'b000000;
          4:       DOOR = 6'b111111;
          default: DOOR = 6'($urandom);
        endcase
        hold = $urandom_range(1, 8);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 4))
          0:       FI = 7'b0110000;
          1:       FI = 7'b1101101;
          2:       FI = 7'b1111001;
          3:       FI = 7'b0000000;
          default: FI = 7'($urandom);
        endcase
      end
      reset = (c >= n / 2) && (c < n / 2 + 2);
    end
    reset    = 1'b0;
    btn_fb   = '0;
    btn_call = '0;
  endtask

  logic [5:0] door_seq [7];

  initial begin
    reset    = 1'b1;
    btn_fb   = '0;
    btn_call = '0;
    FI       = 7'b0000000;
    DOOR     = 6'b111111;
    door_seq = '{6'b110011, 6'b100001, 6'b000000, 6'b000000, 6'b100001, 6'b110011, 6'b111111};
    @(posedge clk);
    #1 chk_en = 1'b1;
    cycles(2);
    reset = 1'b0;

    // Bounce then hold: a single accepted press on CALL1.
    do_reset();
    check("rst_lamp", {26'd0, lamp}, 32'd0);
    check("rst_cnt", {29'd0, pending_cnt}, 32'd0);
    check("rst_stuck", {31'd0, stuck}, 32'd0);
    btn_call[0] = 1'b1; cycles(2);
    btn_call[0] = 1'b0; cycles(2);
    btn_call[0] = 1'b1; cycles(10);
    btn_call[0] = 1'b0; cycles(DEB + 4);
    check("bounce_call1", {31'd0, CALL1}, 32'd1);
    check("bounce_lamp", {26'd0, lamp}, 32'b001000);
    check("bounce_cnt", {29'd0, pending_cnt}, 32'd1);

    // Full door opening at floor 3 serves FB3.
    FI = 7'b1111001;
    do_reset();
    btn_fb[2] = 1'b1; cycles(8);
    btn_fb[2] = 1'b0; cycles(2);
    check("svc_pre", {31'd0, FB3}, 32'd1);
    DOOR = 6'b110011; cycles(2);
    DOOR = 6'b100001; cycles(2);
    check("svc_hold", {31'd0, FB3}, 32'd1);
    DOOR = 6'b000000; cycles(1);
    check("svc_clear", {31'd0, FB3}, 32'd0);
    DOOR = 6'b111111; cycles(2);

    // Set and service on the same edge: served floor loses, other wins.
    FI = 7'b1101101;
    do_reset();
    btn_fb = 3'b011; cycles(DEB + 2);
    DOOR = 6'b000000; cycles(1);
    check("same_edge_fb2", {31'd0, FB2}, 32'd0);
    check("same_edge_fb1", {31'd0, FB1}, 32'd1);
    btn_fb = 3'b000; cycles(DEB + 3);
    check("same_edge_fb2_late", {31'd0, FB2}, 32'd0);
    DOOR = 6'b111111; cycles(2);

    // Unknown floor never serves.
    FI = 7'b0000000;
    do_reset();
    btn_fb[0] = 1'b1; btn_call[1] = 1'b1; cycles(8);
    btn_fb = '0; btn_call = '0;
    foreach (door_seq[i]) begin
      DOOR = door_seq[i];
      cycles(2);
    end
    check("unk_fb1", {31'd0, FB1}, 32'd1);
    check("unk_call2", {31'd0, CALL2}, 32'd1);
    check("unk_cnt", {29'd0, pending_cnt}, 32'd2);

    // Stuck request, sticky across service, cleared by reset.
    do_reset();
    btn_fb[1] = 1'b1; cycles(8);
    btn_fb[1] = 1'b0; cycles(2);
    check("stk_fb2", {31'd0, FB2}, 32'd1);
    cycles(STK - 20);
    check("stk_early", {31'd0, stuck}, 32'd0);
    cycles(30);
    check("stk_set", {31'd0, stuck}, 32'd1);
    FI = 7'b1101101; DOOR = 6'b000000; cycles(2);
    DOOR = 6'b111111; cycles(2);
    check("stk_served", {31'd0, FB2}, 32'd0);
    check("stk_sticky", {31'd0, stuck}, 32'd1);
    reset = 1'b1; cycles(1);
    reset = 1'b0;
    check("stk_reset", {31'd0, stuck}, 32'd0);

    // Reset with five pending and the door open; re-entry to OPEN after.
    FI = 7'b0000000; DOOR = 6'b111111;
    do_reset();
    btn_fb = 3'b111; btn_call = 3'b011; cycles(8);
    btn_fb = '0; btn_call = '0; cycles(2);
    check("five_cnt", {29'd0, pending_cnt}, 32'd5);
    DOOR = 6'b000000; cycles(2);
    check("five_open_cnt", {29'd0, pending_cnt}, 32'd5);
    btn_call[2] = 1'b1;
    reset = 1'b1; cycles(1);
    check("rst_pend", {26'd0, CALL3, CALL2, CALL1, FB3, FB2, FB1}, 32'd0);
    check("rst_lamp2", {26'd0, lamp}, 32'd0);
    check("rst_cnt2", {29'd0, pending_cnt}, 32'd0);
    reset = 1'b0; FI = 7'b0110000; btn_fb[0] = 1'b1;
    cycles(DEB + 4);
    check("open_press_fb1", {31'd0, FB1}, 32'd1);
    check("held_call3", {31'd0, CALL3}, 32'd1);
    btn_fb = '0; btn_call = '0;
    DOOR = 6'b100001; cycles(2);
    DOOR = 6'b000000; cycles(1);
    check("reopen_fb1", {31'd0, FB1}, 32'd0);
    check("reopen_call3", {31'd0, CALL3}, 32'd1);
    DOOR = 6'b111111; cycles(2);

    random_phase(2000);
    cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elevator_request_panel.md
ELEVATOR_REQUEST_PANEL -- requirements
Module: elevator_request_panel

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable synchronized samples required to accept a button level change.
REQ-002 Parameter STUCK_CYCLES, default 1024: cycles a request may stay pending before it is flagged stuck.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 btn_fb  input  3  raw in-car floor buttons; bit n-1 is floor n; asynchronous; bouncy.
REQ-006 btn_call  input  3  raw hall call buttons; bit n-1 is floor n; asynchronous; bouncy.
REQ-007 FI  input  7  controller floor-indicator segment code, bits 7..1 = segments a..g.
REQ-008 DOOR  input  6  controller door pattern: 111111 closed, 110011 open1, 100001 open2, 000000 fully open.
REQ-009 FB1, FB2, FB3  output  1 each  registered pending in-car request level for floors 1-3, sent to the controller.
REQ-010 CALL1, CALL2, CALL3  output  1 each  registered pending hall-call request level for floors 1-3, sent to the controller.
REQ-011 lamp  output  6  button lamps, {call[3:1], fb[3:1]}, equal to the pending latches.
REQ-012 pending_cnt  output  3  population count of the six pending latches, 0-6.
REQ-013 stuck  output  1  sticky flag set when any request exceeds STUCK_CYCLES.

Function
REQ-014 Each raw button passes through a two-flop synchronizer before any other logic.
REQ-015 Debounce per button: accept a new level after DEB_CYCLES consecutive equal synchronized samples that differ from the accepted level; any mismatch restarts the count.
REQ-016 A 0->1 transition of an accepted level sets that button's pending latch on the next clock edge.
REQ-017 A 1->0 accepted transition has no effect; requests clear only on service.
REQ-018 FI decode: 0110000 = floor 1, 1101101 = floor 2, 1111001 = floor 3; any other code = floor 0 (unknown), which never clears a request.
REQ-019 Door-watch FSM states: CLOSED, OPENING, OPEN, CLOSING.
REQ-020 CLOSED -> OPENING when DOOR is neither 111111 nor 000000.
REQ-021 CLOSED or OPENING -> OPEN when DOOR == 000000.
REQ-022 OPEN -> CLOSING when DOOR != 000000.
REQ-023 CLOSING -> CLOSED when DOOR == 111111.
REQ-024 CLOSING -> OPEN when DOOR == 000000 (reopen).
REQ-025 Any unlisted DOOR code holds the current state.
REQ-026 Service: on every transition into OPEN, clear fb[n] and call[n] for the decoded floor n in the same edge. Clearing is one cycle after DOOR first reads 000000.
REQ-027 Set and clear on the same edge for the same latch: clear wins, because the floor is being served.
REQ-028 Set of a latch for any other floor on that edge proceeds normally.
REQ-029 A button pressed at the served floor while the FSM remains in OPEN sets the latch; it clears on the next entry to OPEN.
REQ-030 FB/CALL outputs, lamp and pending_cnt are registered and track the latches with zero additional latency.
REQ-031 pending_cnt reflects the post-update latch state of the same edge.
REQ-032 Each latch has its own 11-bit age counter:
  - counts while the latch is set, saturating;
  - clears when the latch clears;
  - stuck sets when any age counter reaches STUCK_CYCLES.
REQ-033 stuck clears only on reset.
REQ-034 Multiple simultaneous presses set all their latches on the same edge; no arbitration or priority is applied.

Reset
REQ-035 When reset is asserted, the following clear at the next edge:
  - all pending latches, FB1-3, CALL1-3 -> 0;
  - lamp -> 000000, pending_cnt -> 0, stuck -> 0;
  - age counters -> 0;
  - synchronizers and debounce counters -> 0, accepted levels -> 0;
  - door FSM -> CLOSED.
REQ-036 Reset asserted mid-debounce or mid-service discards that progress. A button still held high after reset is accepted DEB_CYCLES+2 cycles after deassertion and sets its latch.

Verification
REQ-037 Bounce btn_call[1] 1/0/1 with gaps of 2 cycles, then hold it high 10 cycles -> exactly one latch set: CALL1=1, lamp=001000, pending_cnt=1.
REQ-038 With FB3 pending and FI=1111001, drive DOOR 111111 -> 110011 -> 100001 -> 000000 -> FB3=0 one cycle after the 000000 sample, and the FSM passes OPENING then OPEN.
REQ-039 With FI=1101101 and DOOR entering 000000 on the same edge btn_fb[2] is accepted -> FB2 stays 0; btn_fb[1] accepted on that edge -> FB1=1.
REQ-040 With FI=0000000 (unknown) and a full door cycle, FB1 and CALL2 pending -> both remain 1 and pending_cnt=2.
REQ-041 Hold FB2 pending with no service for STUCK_CYCLES cycles -> stuck=1 and it stays 1 after service; reset -> stuck=0.
REQ-042 Assert reset with 5 latches pending and DOOR=000000 -> all outputs 0 next edge and the FSM goes to CLOSED; after deassert, DOOR held at 000000 -> the FSM enters OPEN with nothing to clear.
